// File: rtl/tendon_spike_encoder.sv
// Float force -> Q16.16 rate integrator emitting per-step spike counts and per-frame totals.
// Latency: step outputs and frame total 1 cycle after the step; the one-deep frame buffer drops new totals when full and unaccepted.
module tendon_spike_encoder #(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_force,
    input  logic        i_step,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic        i_ready,
    output logic        o_spike,
    output logic [15:0] o_step_spikes,
    output logic [31:0] o_spike_cnt,
    output logic        o_valid,
    output logic        o_overrun
);

    localparam logic [15:0] LAST_STEP = 16'(FRAME_LEN - 1);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    buf_state_t  state_q, state_d;
    logic [15:0] frac_q, frac_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [15:0] step_spk_q, step_spk_d;
    logic        spike_q, spike_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;

    logic        f_sign;
    logic [7:0]  f_exp;
    logic [23:0] f_mant;
    logic [31:0] conv;
    logic [31:0] rate;
    logic [32:0] sum;
    logic [15:0] step_spk;
    logic [32:0] acc_sum;
    logic [31:0] acc_sat;
    logic        counted;
    logic        frame_end;

    assign f_sign = f_force[31];
    assign f_exp  = f_force[30:23];
    assign f_mant = {1'b1, f_force[22:0]};

    // Value in Q16.16 is mant24 * 2^(exp-134); exp >= 143 means value >= 2^16.
    always_comb begin
        conv = '0;
        if (f_sign || f_exp == 8'd0 || (f_exp == 8'hFF && f_force[22:0] != 23'd0)) begin
            conv = '0;
        end else if (f_exp >= 8'd143) begin
            conv = '1;
        end else if (f_exp >= 8'd134) begin
            conv = {8'd0, f_mant} << (f_exp - 8'd134);
        end else if (f_exp > 8'd110) begin
            conv = {8'd0, f_mant} >> (8'd134 - f_exp);
        end
    end

    assign rate      = conv >> GAIN_SHIFT;
    assign sum       = {17'd0, frac_q} + {1'b0, rate};
    assign step_spk  = sum[32] ? 16'hFFFF : sum[31:16];
    assign acc_sum   = {1'b0, acc_q} + {17'd0, step_spk};
    assign acc_sat   = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    assign counted   = i_step & i_enable & ~i_clear;
    assign frame_end = counted && (step_cnt_q == LAST_STEP);

    always_comb begin
        state_d     = state_q;
        frac_d      = frac_q;
        acc_d       = acc_q;
        step_cnt_d  = step_cnt_q;
        step_spk_d  = step_spk_q;
        spike_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (i_clear) begin
            frac_d     = '0;
            acc_d      = '0;
            step_cnt_d = '0;
            step_spk_d = '0;
            overrun_d  = 1'b0;
        end else if (counted) begin
            frac_d     = sum[15:0];
            step_spk_d = step_spk;
            spike_d    = (step_spk != 16'd0);
            if (frame_end) begin
                step_cnt_d = '0;
                acc_d      = '0;
            end else begin
                step_cnt_d = step_cnt_q + 16'd1;
                acc_d      = acc_sat;
            end
        end

        // Frame end only happens on a counted step, so it never races i_clear on overrun.
        case (state_q)
            BUF_EMPTY: begin
                if (frame_end) begin
                    state_d     = BUF_FULL;
                    frame_cnt_d = acc_sat;
                end
            end
            BUF_FULL: begin
                if (frame_end) begin
                    if (i_ready) frame_cnt_d = acc_sat;
                    else         overrun_d   = 1'b1;
                end else if (i_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BUF_EMPTY;
            frac_q      <= '0;
            acc_q       <= '0;
            step_cnt_q  <= '0;
            step_spk_q  <= '0;
            spike_q     <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frac_q      <= frac_d;
            acc_q       <= acc_d;
            step_cnt_q  <= step_cnt_d;
            step_spk_q  <= step_spk_d;
            spike_q     <= spike_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_spike       = spike_q;
    assign o_step_spikes = step_spk_q;
    assign o_spike_cnt   = frame_cnt_q;
    assign o_valid       = (state_q == BUF_FULL);
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_tendon_spike_encoder.sv
// Three encoder configurations driven by shared random/directed stimulus, checked against an arithmetic reference.
module tb_tendon_spike_encoder;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_force;
    logic        i_step, i_enable, i_clear, i_ready;

    logic        o_spike_w [ND];
    logic [15:0] o_step_w  [ND];
    logic [31:0] o_cnt_w   [ND];
    logic        o_valid_w [ND];
    logic        o_ovr_w   [ND];

    always #5 clk = ~clk;

    tendon_spike_encoder #(.FRAME_LEN(8), .GAIN_SHIFT(0)) u_a (
        .clk(clk), .reset(reset), .f_force(f_force), .i_step(i_step), .i_enable(i_enable),
        .i_clear(i_clear), .i_ready(i_ready), .o_spike(o_spike_w[0]), .o_step_spikes(o_step_w[0]),
        .o_spike_cnt(o_cnt_w[0]), .o_valid(o_valid_w[0]), .o_overrun(o_ovr_w[0]));

    tendon_spike_encoder #(.FRAME_LEN(4), .GAIN_SHIFT(0)) u_b (
        .clk(clk), .reset(reset), .f_force(f_force), .i_step(i_step), .i_enable(i_enable),
        .i_clear(i_clear), .i_ready(i_ready), .o_spike(o_spike_w[1]), .o_step_spikes(o_step_w[1]),
        .o_spike_cnt(o_cnt_w[1]), .o_valid(o_valid_w[1]), .o_overrun(o_ovr_w[1]));

    tendon_spike_encoder #(.FRAME_LEN(8), .GAIN_SHIFT(2)) u_c (
        .clk(clk), .reset(reset), .f_force(f_force), .i_step(i_step), .i_enable(i_enable),
        .i_clear(i_clear), .i_ready(i_ready), .o_spike(o_spike_w[2]), .o_step_spikes(o_step_w[2]),
        .o_spike_cnt(o_cnt_w[2]), .o_valid(o_valid_w[2]), .o_overrun(o_ovr_w[2]));

    int total = 0;
    int bad   = 0;

    // Reference state per configuration
    longint      mF   [ND];
    longint      macc [ND];
    int          mcnt [ND];
    longint      mstep[ND];
    bit          mspike[ND];
    bit          mvalid[ND];
    bit          movr [ND];
    logic [31:0] eq   [ND][4];
    int          eh   [ND];
    int          en   [ND];

    function automatic int fl(input int d);
        return (d == 1) ? 4 : 8;
    endfunction

    function automatic int gs(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    // Real-valued interpretation of the float, scaled by 2^16 and truncated.
    function automatic longint conv(input logic [31:0] b);
        int     e;
        real    v, q;
        longint t;
        e = int'(b[30:23]);
        if (b[31] || e == 0 || (e == 255 && b[22:0] != 23'd0)) return 0;
        if (e == 255) return 64'hFFFF_FFFF;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (v >= 65536.0) return 64'hFFFF_FFFF;
        q = v * 65536.0;
        t = longint'(q);
        if (real'(t) > q) t = t - 1;
        return t;
    endfunction

    task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            mF[d] = 0; macc[d] = 0; mcnt[d] = 0; mstep[d] = 0;
            mspike[d] = 0; mvalid[d] = 0; movr[d] = 0; eh[d] = 0; en[d] = 0;
        end
    endtask

    task automatic push(input int d, input longint v);
        eq[d][(eh[d] + en[d]) % 4] = v[31:0];
        en[d]++;
    endtask

    task automatic model_edge();
        bit     counted, fe;
        longint r, s, sp, tot;
        counted = i_step && i_enable && !i_clear;
        for (int d = 0; d < ND; d++) begin
            fe = 0;
            tot = 0;
            mspike[d] = 0;
            if (i_clear) begin
                mF[d] = 0; macc[d] = 0; mcnt[d] = 0; mstep[d] = 0; movr[d] = 0;
            end else if (counted) begin
                r  = conv(f_force) >> gs(d);
                s  = mF[d] + r;
                sp = s / 65536;
                if (sp > 65535) sp = 65535;
                mF[d]     = s % 65536;
                mstep[d]  = sp;
                mspike[d] = (sp != 0);
                tot = macc[d] + sp;
                if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
                mcnt[d]++;
                if (mcnt[d] == fl(d)) begin
                    fe = 1; mcnt[d] = 0; macc[d] = 0;
                end else begin
                    macc[d] = tot;
                end
            end
            if (fe) begin
                if (!mvalid[d]) begin
                    push(d, tot);
                    mvalid[d] = 1;
                end else if (i_ready) begin
                    push(d, tot);
                end else begin
                    movr[d] = 1;
                end
            end else if (mvalid[d] && i_ready) begin
                mvalid[d] = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            check({tag, ".spike"},   d, 64'(o_spike_w[d]), 64'(mspike[d]));
            check({tag, ".step"},    d, 64'(o_step_w[d]),  mstep[d]);
            check({tag, ".valid"},   d, 64'(o_valid_w[d]), 64'(mvalid[d]));
            check({tag, ".overrun"}, d, 64'(o_ovr_w[d]),   64'(movr[d]));
            if (!reset) check({tag, ".cnt_rst"}, d, 64'(o_cnt_w[d]), 64'd0);
        end
    endtask

    // Frame-total monitor: compares the buffered total and pops on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                if (o_valid_w[d]) begin
                    if (en[d] == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_unexpected dut%0d: got %0h expected no frame", d, o_cnt_w[d]);
                    end else begin
                        check("frame_cnt", d, 64'(o_cnt_w[d]), 64'(eq[d][eh[d]]));
                        if (i_ready) begin
                            eh[d] = (eh[d] + 1) % 4;
                            en[d]--;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input bit st, input bit ena, input bit clr, input bit rdy);
        i_step = st; i_enable = ena; i_clear = clr; i_ready = rdy;
        @(posedge clk);
        if (reset) model_edge();
        else       model_reset();
        #1;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_force();
        logic [31:0] v;
        case ($urandom_range(0, 11))
            0:       v = {1'b1, 8'($urandom_range(100, 140)), 23'($urandom)};
            1:       v = {1'b0, 8'hFF, 23'($urandom) | 23'd1};
            2:       v = 32'h7F80_0000;
            3:       v = {1'b0, 8'd0, 23'($urandom)};
            4:       v = {1'b0, 8'($urandom_range(142, 150)), 23'($urandom)};
            default: v = {1'b0, 8'($urandom_range(105, 135)), 23'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] specials [6];
        specials[0] = 32'hBF80_0000;
        specials[1] = 32'h7FC0_0000;
        specials[2] = 32'h0000_0001;
        specials[3] = 32'h7F80_0000;
        specials[4] = 32'h4780_0000;
        specials[5] = 32'h477F_FF80;

        reset = 1'b1; f_force = '0; i_step = 0; i_enable = 0; i_clear = 0; i_ready = 1;
        model_reset();
        #2;
        do_reset();

        // Force 1.0: one spike per step, frames of 8/4 and 2 at quarter gain
        f_force = 32'h3F80_0000;
        for (int i = 0; i < 16; i++) tick(1, 1, 0, 1);
        tick(0, 1, 0, 1);

        // Force 0.25 with idle gaps
        f_force = 32'h3E80_0000;
        for (int i = 0; i < 16; i++) begin
            tick(1, 1, 0, 1);
            tick(0, 1, 0, 1);
        end

        // Backpressure across several frame ends -> overrun
        f_force = 32'h3F80_0000;
        tick(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) tick(1, 1, 0, 0);
        // Clear drops overrun but keeps the held frame; ready lands on the next frame end
        tick(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
        tick(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 1);

        // Special float encodings
        for (int k = 0; k < 6; k++) begin
            f_force = specials[k];
            for (int i = 0; i < 3; i++) tick(1, 1, 0, 1);
        end

        // Enable low freezes, clear mid-frame restarts counting
        f_force = 32'h3FC0_0000;
        tick(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1);
        tick(1, 1, 1, 1);
        for (int i = 0; i < 9; i++) tick(1, 1, 0, 1);

        // Reset mid-frame while a frame is held
        f_force = 32'h3F80_0000;
        tick(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) tick(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 9; i++) tick(1, 1, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) f_force = rand_force();
            if ($urandom_range(0, 999) == 0) do_reset();
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 17,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
        end

        for (int i = 0; i < 6; i++) tick(0, 1, 0, 1);
        for (int d = 0; d < ND; d++) check("drain", d, 64'(en[d]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tendon_spike_encoder.md
TENDON_SPIKE_ENCODER -- requirements
Module: tendon_spike_encoder

Interface
REQ-001 Parameter FRAME_LEN, default 1024: simulation steps per output frame; legal range 1..65535.
REQ-002 Parameter GAIN_SHIFT, default 0: right shift applied to the converted rate; legal range 0..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 f_force  input  32  IEEE-754 single; force in spikes-per-step units.
REQ-006 i_step  input  1  one-cycle simulation-step strobe.
REQ-007 i_enable  input  1  step gate; steps are ignored while low.
REQ-008 i_clear  input  1  synchronous clear of the integration state.
REQ-009 i_ready  input  1  consumer accepts o_spike_cnt.
REQ-010 o_spike  output  1  one-cycle pulse when a step yields at least one spike.
REQ-011 o_step_spikes  output  16  spikes produced by the last counted step.
REQ-012 o_spike_cnt  output  32  integer spike total of the last completed frame.
REQ-013 o_valid  output  1  o_spike_cnt holds an unaccepted frame.
REQ-014 o_overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-015 A counted step SHALL be a cycle with i_step=1, i_enable=1 and i_clear=0.
REQ-016 f_force SHALL be converted combinationally to unsigned Q16.16 rate R as follows:
- sign=1, exponent=0 or NaN -> 0.
- +inf, or value >= 2^16 -> 0xFFFFFFFF.
- otherwise truncate toward zero.
- then R = converted >> GAIN_SHIFT.
REQ-017 The block SHALL hold a 16-bit fractional residue F and compute the 33-bit sum S = F + R on each counted step.
REQ-018 On a counted step the block SHALL register F <= S[15:0] and o_step_spikes <= S[31:16], saturated to 0xFFFF when S[32] is set.
REQ-019 o_spike SHALL be 1 in the cycle after a counted step whose spike count is nonzero, and 0 otherwise.
REQ-020 The frame accumulator SHALL add each step's spike count and saturate at 0xFFFFFFFF.
REQ-021 The step counter SHALL increment once per counted step.
REQ-022 On the counted step that brings the step counter to FRAME_LEN (the frame-end step):
- the step counter SHALL wrap to 0;
- the accumulator SHALL restart at 0;
- the completed total, including that step's spikes, SHALL be offered to the output buffer.
REQ-023 The output buffer SHALL be a two-state machine.
- EMPTY -> FULL on the frame-end step: load o_spike_cnt and set o_valid=1 in the next cycle.
- FULL -> EMPTY when i_ready=1 with no simultaneous frame end.
- FULL with a frame end and i_ready=1 in the same cycle: accept the old value and load the new one; stay FULL; o_overrun unchanged.
- FULL with a frame end and i_ready=0: keep the old value, discard the new one, set o_overrun=1.
REQ-024 Frame latency SHALL be exactly 1 cycle from the frame-end step to o_valid=1.
REQ-025 o_spike_cnt SHALL remain stable while o_valid=1 and i_ready=0.
REQ-026 i_clear=1 SHALL zero F, the accumulator, the step counter and o_step_spikes, and SHALL also clear o_overrun.
REQ-027 i_clear SHALL NOT affect the output buffer or o_valid, and a step coinciding with i_clear SHALL be ignored.
REQ-028 i_enable=0 SHALL freeze F, the accumulator and the step counter, and SHALL hold o_spike low.
REQ-029 A change of f_force SHALL take effect on the next counted step, with no filtering.

Reset
REQ-030 Asserting reset SHALL immediately force every register and output to 0, at any point in operation, including mid-frame and while o_valid=1.
REQ-031 After reset is released, counting SHALL restart from step 0 with F=0.

Verification
REQ-032 FRAME_LEN=8, f_force=0x3F800000 (1.0), 8 steps -> o_spike every step, o_step_spikes=1, o_valid 1 cycle after step 8, o_spike_cnt=8.
REQ-033 FRAME_LEN=8, f_force=0x3E800000 (0.25) -> o_spike on steps 4 and 8 only, o_spike_cnt=2, F=0 at frame end.
REQ-034 f_force values 0xBF800000, 0x7FC00000 and 0x00000001 -> 0 spikes; 0x7F800000 -> o_step_spikes=0xFFFF each step.
REQ-035 FRAME_LEN=4, force 1.0, i_ready=0 over two frame ends -> o_spike_cnt stays 4 and o_overrun=1.
- With i_ready=1 coinciding with a frame end: new value loaded, o_overrun unchanged.
REQ-036 Reset asserted after step 5 of 8 -> all outputs 0 asynchronously; after release, the next frame completes 8 steps later with o_spike_cnt=8.
REQ-037 GAIN_SHIFT=2, force 1.0, FRAME_LEN=8 -> o_spike_cnt=2; i_clear mid-frame -> step counter restarts and o_valid is unchanged.
